// File: rtl/vad_decide_pkg.sv
// rtl/vad_decide_pkg.sv - shared VAD types and widths for the MAC and decision stages
package vad_decide_pkg;

    typedef enum logic [1:0] {
        SIL    = 2'd0,
        ONSET  = 2'd1,
        SPEECH = 2'd2,
        HANG   = 2'd3
    } vad_state_e;

    localparam int VAD_SCORE_W     = 10;
    localparam int VAD_FRAME_CNT_W = 16;

endpackage

// File: rtl/vad_out_buf.sv
// rtl/vad_out_buf.sv - single-entry result buffer with valid/ready handshake and sticky overrun
module vad_out_buf #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         overrun_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         overrun_q, overrun_d;

    // A load always wins over the drain, so a coinciding handshake keeps valid high
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            if (valid_q && !ready_i) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/vad_decide.sv
// rtl/vad_decide.sv - per-frame speech decision with onset/hangover smoothing
module vad_decide
    import vad_decide_pkg::*;
#(
    parameter int SCORE_W      = VAD_SCORE_W,
    parameter int THRESH       = 0,
    parameter int ONSET_FRAMES = 3,
    parameter int HANG_FRAMES  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [SCORE_W-1:0]   score_noise,
    input  logic signed [SCORE_W-1:0]   score_speech,
    input  logic                        score_valid,
    output logic                        vad_flag,
    output logic                        raw_flag,
    output logic                        vad_valid,
    input  logic                        vad_ready,
    output logic                        overrun,
    output logic [VAD_FRAME_CNT_W-1:0]  frame_cnt
);

    localparam logic signed [SCORE_W:0] THR_C   = (SCORE_W+1)'(THRESH);
    localparam logic [5:0]              ONSET_C = 6'(ONSET_FRAMES);
    localparam logic [5:0]              HANG_C  = 6'(HANG_FRAMES);

    vad_state_e                  state_q, state_d;
    logic [5:0]                  cnt_q, cnt_d, cnt_inc;
    logic [VAD_FRAME_CNT_W-1:0]  frame_cnt_q;
    logic signed [SCORE_W:0]     margin_d;
    logic                        is_speech_d;
    logic                        vad_flag_d;
    logic [1:0]                  buf_data;

    // One extra bit keeps the difference of two full-range scores exact
    assign margin_d    = {score_speech[SCORE_W-1], score_speech}
                       - {score_noise[SCORE_W-1], score_noise};
    assign is_speech_d = margin_d > THR_C;
    assign cnt_inc     = cnt_q + 6'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SIL: begin
                if (is_speech_d) begin
                    if (ONSET_C == 6'd1) begin
                        state_d = SPEECH;
                        cnt_d   = 6'd0;
                    end else begin
                        state_d = ONSET;
                        cnt_d   = 6'd1;
                    end
                end
            end
            ONSET: begin
                if (!is_speech_d) begin
                    state_d = SIL;
                    cnt_d   = 6'd0;
                end else if (cnt_inc == ONSET_C) begin
                    state_d = SPEECH;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            SPEECH: begin
                if (!is_speech_d) begin
                    if (HANG_C == 6'd1) begin
                        state_d = SIL;
                        cnt_d   = 6'd0;
                    end else begin
                        state_d = HANG;
                        cnt_d   = 6'd1;
                    end
                end
            end
            HANG: begin
                if (is_speech_d) begin
                    state_d = SPEECH;
                    cnt_d   = 6'd0;
                end else if (cnt_inc == HANG_C) begin
                    state_d = SIL;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = SIL;
                cnt_d   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SIL;
            cnt_q       <= 6'd0;
            frame_cnt_q <= '0;
        end else if (score_valid) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    assign vad_flag_d = (state_d == SPEECH) || (state_d == HANG);

    vad_out_buf #(
        .W(2)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .load_i    (score_valid),
        .data_i    ({is_speech_d, vad_flag_d}),
        .ready_i   (vad_ready),
        .valid_o   (vad_valid),
        .data_o    (buf_data),
        .overrun_o (overrun)
    );

    assign {raw_flag, vad_flag} = buf_data;
    assign frame_cnt            = frame_cnt_q;

endmodule
